// File: rtl/spi_slave_std.sv
// Mode-0 (CPOL=0, CPHA=0, MSB first) SPI slave with every pin oversampled in HCLK.
// MOSI is deserialised onto a valid/ready RX port; TX words are serialised onto MISO.
module spi_slave_std #(
   parameter int unsigned             DATA_WIDTH   = 32,
   parameter logic [DATA_WIDTH-1:0]   TX_IDLE_WORD = 32'hFFFF_FFFF
) (
   input  logic                  HCLK,
   input  logic                  HRESET,
   input  logic                  spi_sclk_i,
   input  logic                  spi_csn_i,
   input  logic                  spi_sdi_i,
   output logic                  spi_sdo_o,
   output logic                  spi_oe_o,
   output logic [DATA_WIDTH-1:0] rx_data_o,
   output logic                  rx_valid_o,
   input  logic                  rx_ready_i,
   input  logic [DATA_WIDTH-1:0] tx_data_i,
   input  logic                  tx_valid_i,
   output logic                  tx_ready_o,
   output logic                  eot_o,
   output logic                  rx_overrun_o,
   output logic                  tx_underrun_o,
   output logic                  busy_o
);

   localparam int unsigned      CNT_W    = $clog2(DATA_WIDTH) + 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

   typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

   logic [2:0]            sclk_q;
   logic [2:0]            csn_q;
   logic [1:0]            sdi_q;
   state_t                state_q;
   logic [CNT_W-1:0]      bit_cnt_q;
   logic [DATA_WIDTH-1:0] shift_rx_q;
   logic [DATA_WIDTH-1:0] shift_tx_q;
   logic [DATA_WIDTH-1:0] rx_data_q;
   logic                  rx_done_q;
   logic                  rx_valid_q;
   logic                  eot_q;
   logic                  overrun_q;
   logic                  underrun_q;

   logic                  sclk_rise;
   logic                  sclk_fall;
   logic                  csn_rise;
   logic                  csn_fall;
   logic                  active;
   logic                  tx_load;
   logic [DATA_WIDTH-1:0] tx_word_d;
   logic [DATA_WIDTH-1:0] shift_rx_d;

   assign sclk_rise  = sclk_q[1] & ~sclk_q[2];
   assign sclk_fall  = ~sclk_q[1] & sclk_q[2];
   assign csn_rise   = csn_q[1] & ~csn_q[2];
   assign csn_fall   = ~csn_q[1] & csn_q[2];
   assign active     = (state_q == ACTIVE);
   // Load at selection, and on the first SCK fall of every following word.
   assign tx_load    = (~active & csn_fall)
                     | (active & ~csn_rise & sclk_fall & (bit_cnt_q == '0));
   assign tx_word_d  = tx_valid_i ? tx_data_i : TX_IDLE_WORD;
   assign shift_rx_d = {shift_rx_q[DATA_WIDTH-2:0], sdi_q[1]};

   // Pin synchronisers with a third stage on sclk and csn for edge detection.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         sclk_q <= 3'b000;
         csn_q  <= 3'b111;
         sdi_q  <= 2'b00;
      end else begin
         sclk_q <= {sclk_q[1:0], spi_sclk_i};
         csn_q  <= {csn_q[1:0], spi_csn_i};
         sdi_q  <= {sdi_q[0], spi_sdi_i};
      end
   end

   // Transaction FSM with the RX/TX shift registers and bit counter.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_q    <= IDLE;
         bit_cnt_q  <= '0;
         shift_rx_q <= '0;
         shift_tx_q <= '0;
         rx_done_q  <= 1'b0;
         eot_q      <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         eot_q      <= 1'b0;
         rx_done_q  <= 1'b0;
         underrun_q <= tx_load & ~tx_valid_i;
         if (tx_load) begin
            shift_tx_q <= tx_word_d;
         end
         case (state_q)
            IDLE: begin
               if (csn_fall) begin
                  state_q   <= ACTIVE;
                  bit_cnt_q <= '0;
               end
            end
            ACTIVE: begin
               // Deselect wins over a coincident last-bit SCK rise.
               if (csn_rise) begin
                  state_q    <= IDLE;
                  eot_q      <= 1'b1;
                  bit_cnt_q  <= '0;
                  shift_rx_q <= '0;
                  shift_tx_q <= '0;
               end else if (sclk_rise) begin
                  shift_rx_q <= shift_rx_d;
                  if (bit_cnt_q == LAST_BIT) begin
                     bit_cnt_q <= '0;
                     rx_done_q <= 1'b1;
                  end else begin
                     bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                  end
               end else if (sclk_fall && (bit_cnt_q != '0)) begin
                  shift_tx_q <= {shift_tx_q[DATA_WIDTH-2:0], 1'b0};
               end
            end
            default: begin
               state_q   <= IDLE;
               bit_cnt_q <= '0;
            end
         endcase
      end
   end

   // RX output holding register: a completed word is dropped while one is still pending.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         overrun_q <= 1'b0;
         if (rx_done_q) begin
            if (rx_valid_q && !rx_ready_i) begin
               overrun_q <= 1'b1;
            end else begin
               rx_data_q  <= shift_rx_q;
               rx_valid_q <= 1'b1;
            end
         end else if (rx_valid_q && rx_ready_i) begin
            rx_valid_q <= 1'b0;
         end
      end
   end

   assign spi_sdo_o     = active & shift_tx_q[DATA_WIDTH-1];
   assign spi_oe_o      = active;
   assign busy_o        = active;
   assign tx_ready_o    = tx_load;
   assign rx_data_o     = rx_data_q;
   assign rx_valid_o    = rx_valid_q;
   assign eot_o         = eot_q;
   assign rx_overrun_o  = overrun_q;
   assign tx_underrun_o = underrun_q;

endmodule
